// File: rtl/sobel_pkg.sv
// Shared types for the Sobel datapath.
//   dir_t      : move encoding, common with move_control
//   wb_state_t : window_buffer control states
//   PIX_W_DFLT : default pixel width
package sobel_pkg;

  localparam int PIX_W_DFLT = 8;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'b00,
    WB_FILL  = 2'b01,
    WB_SHIFT = 2'b10,
    WB_READY = 2'b11
  } wb_state_t;

endpackage

// File: rtl/window_buffer.sv
// window_buffer: builds the 3x3 Sobel neighbourhood from the serial SRAM
// pixel stream. A 9-pixel fill loads the whole window in row-major order.
// A move (right/left/down) slides the window in place and then takes
// 3 pixels for the vacated column or row.
//
// Ports
//   clk, n_reset   clock, async active-low reset
//   fill_start     begin 9-pixel fill (also aborts a fill/shift in flight)
//   shift_start    begin 3-pixel move update, direction sampled with it
//   direction      dir_t encoding, 00 is a protocol error
//   pix_valid      pix_data qualifier
//   pix_data       pixel from SRAM
//   win_ack        consumer took the window (sampled in READY only)
//   window         element (r,c) at [PIX_W*(3r+c) +: PIX_W]
//   window_valid   window complete and stable
//   busy           FILL or SHIFT in progress
//   err            sticky protocol error, cleared by an accepted fill
//   win_count      acked windows, wraps (only with WINBUF_WIN_COUNT_EN)
//
// Optional feature macro: WINBUF_WIN_COUNT_EN
module window_buffer
  import sobel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DFLT
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               fill_start,
  input  logic               shift_start,
  input  logic [1:0]         direction,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               win_ack,
  output logic [9*PIX_W-1:0] window,
  output logic               window_valid,
  output logic               busy,
`ifdef WINBUF_WIN_COUNT_EN
  output logic [15:0]        win_count,
`endif
  output logic               err
);

  wb_state_t             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  dir_t                  dir_q, dir_d;
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic                  valid_q, busy_q;
  logic                  ack_take;
  logic [3:0]            slot;
  logic [3:0]            last;
  dir_t                  dir_in;

  assign dir_in = dir_t'(direction);

  // Destination element of the current beat, and the cnt of the final beat.
  always_comb begin
    slot = cnt_q;
    last = 4'd8;
    if (state_q == WB_SHIFT) begin
      last = 4'd2;
      case (dir_q)
        DIR_RIGHT: slot = (cnt_q << 1) + cnt_q + 4'd2;
        DIR_LEFT:  slot = (cnt_q << 1) + cnt_q;
        default:   slot = cnt_q + 4'd6;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    dir_d    = dir_q;
    win_d    = win_q;
    ack_take = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (pix_valid) err_d = 1'b1;
        // fill has priority; a coincident shift is silently dropped
        if (fill_start) begin
          state_d = WB_FILL;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
        end else if (shift_start) begin
          if (dir_in == DIR_NONE) begin
            err_d = 1'b1;
          end else begin
            state_d = WB_SHIFT;
            cnt_d   = 4'd0;
            dir_d   = dir_in;
            // slide in place on the accepting edge; vacated slots stay stale
            case (dir_in)
              DIR_RIGHT: begin
                win_d[0] = win_q[1]; win_d[1] = win_q[2];
                win_d[3] = win_q[4]; win_d[4] = win_q[5];
                win_d[6] = win_q[7]; win_d[7] = win_q[8];
              end
              DIR_LEFT: begin
                win_d[2] = win_q[1]; win_d[1] = win_q[0];
                win_d[5] = win_q[4]; win_d[4] = win_q[3];
                win_d[8] = win_q[7]; win_d[7] = win_q[6];
              end
              default: begin
                win_d[2:0] = win_q[5:3];
                win_d[5:3] = win_q[8:6];
              end
            endcase
          end
        end
      end
      WB_FILL, WB_SHIFT: begin
        if (fill_start) begin
          state_d = WB_FILL;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
        end else begin
          if (shift_start) err_d = 1'b1;
          if (pix_valid) begin
            win_d[slot] = pix_data;
            cnt_d       = cnt_q + 4'd1;
            if (cnt_q == last) state_d = WB_READY;
          end
        end
      end
      WB_READY: begin
        if (pix_valid) err_d = 1'b1;
        if (fill_start) begin
          state_d = WB_FILL;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
        end else if (win_ack) begin
          state_d  = WB_IDLE;
          ack_take = 1'b1;
        end else if (shift_start) begin
          err_d = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= WB_IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      dir_q   <= DIR_RIGHT;
      win_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      // status flags registered from next state so outputs are pure flops
      valid_q <= (state_d == WB_READY);
      busy_q  <= (state_d == WB_FILL) || (state_d == WB_SHIFT);
    end
  end

`ifdef WINBUF_WIN_COUNT_EN
  logic [15:0] win_count_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)      win_count_q <= 16'd0;
    else if (ack_take) win_count_q <= win_count_q + 16'd1;
  end

  assign win_count = win_count_q;
`else
  logic unused_ack;
  assign unused_ack = ack_take;
`endif

  assign window       = win_q;
  assign window_valid = valid_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_window_buffer.sv
// Directed bench for window_buffer. Inputs driven and outputs sampled on
// the falling edge; expected windows are hand-built constants.
module tb_window_buffer;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        fill_start, shift_start, pix_valid, win_ack;
  logic [1:0]  direction;
  logic [7:0]  pix_data;
  logic [71:0] window;
  logic        window_valid, busy, err;
`ifdef WINBUF_WIN_COUNT_EN
  logic [15:0] win_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int acks  = 0;

  always #5 clk = ~clk;

  window_buffer #(.PIX_W(8)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .fill_start   (fill_start),
    .shift_start  (shift_start),
    .direction    (direction),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .win_ack      (win_ack),
    .window       (window),
    .window_valid (window_valid),
    .busy         (busy),
`ifdef WINBUF_WIN_COUNT_EN
    .win_count    (win_count),
`endif
    .err          (err)
  );

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mkwin(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {8'(p8), 8'(p7), 8'(p6), 8'(p5), 8'(p4), 8'(p3), 8'(p2), 8'(p1), 8'(p0)};
  endfunction

  task automatic beat(input int v);
    pix_valid = 1'b1;
    pix_data  = 8'(v);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  // fill with first..first+8, gap idle cycles between beats
  task automatic fill_seq(input int first, input int gap);
    fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    chk("fill_busy", 72'(busy), 72'd1);
    chk("fill_err_clr", 72'(err), 72'd0);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("fill_valid_early", 72'(window_valid), 72'd0);
      beat(first + i);
      if (i != 8) repeat (gap) @(negedge clk);
    end
    chk("fill_valid", 72'(window_valid), 72'd1);
    chk("fill_busy_done", 72'(busy), 72'd0);
  endtask

  task automatic shift_seq(input logic [1:0] d, input int first);
    shift_start = 1'b1;
    direction   = d;
    @(negedge clk);
    shift_start = 1'b0;
    direction   = 2'b00;
    chk("shift_busy", 72'(busy), 72'd1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) chk("shift_valid_early", 72'(window_valid), 72'd0);
      beat(first + i);
    end
    chk("shift_valid", 72'(window_valid), 72'd1);
  endtask

  task automatic ack();
    win_ack = 1'b1;
    @(negedge clk);
    win_ack = 1'b0;
    acks++;
    chk("ack_valid_fall", 72'(window_valid), 72'd0);
  endtask

  initial begin
    n_reset = 1'b0; fill_start = 1'b0; shift_start = 1'b0; direction = 2'b00;
    pix_valid = 1'b0; pix_data = 8'd0; win_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_window", window, 72'd0);
    chk("rst_valid", 72'(window_valid), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    chk("rst_err", 72'(err), 72'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // plain fill
    fill_seq(1, 0);
    chk("fill_win", window, mkwin(1, 2, 3, 4, 5, 6, 7, 8, 9));
    ack();

    // right shift
    shift_seq(2'b01, 10);
    chk("right_win", window, mkwin(2, 3, 10, 5, 6, 11, 8, 9, 12));
    ack();

    // left shift from fresh base
    fill_seq(1, 0); ack();
    shift_seq(2'b10, 20);
    chk("left_win", window, mkwin(20, 1, 2, 21, 4, 5, 22, 7, 8));
    ack();

    // down shift from fresh base
    fill_seq(1, 0); ack();
    shift_seq(2'b11, 30);
    chk("down_win", window, mkwin(4, 5, 6, 7, 8, 9, 30, 31, 32));
    ack();

    // gapped fill, beats 3 cycles apart
    fill_seq(1, 2);
    chk("gap_win", window, mkwin(1, 2, 3, 4, 5, 6, 7, 8, 9));
    ack();

    // pix_valid while IDLE: sticky err until next fill
    beat(99);
    chk("idle_pix_err", 72'(err), 72'd1);
    repeat (3) @(negedge clk);
    chk("idle_pix_err_sticky", 72'(err), 72'd1);
    chk("idle_pix_win", window, mkwin(1, 2, 3, 4, 5, 6, 7, 8, 9));
    fill_seq(1, 0); ack();

    // illegal direction
    shift_start = 1'b1; direction = 2'b00;
    @(negedge clk);
    shift_start = 1'b0;
    chk("dir0_err", 72'(err), 72'd1);
    chk("dir0_idle", 72'(busy), 72'd0);

    // async reset mid-fill
    fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    for (int i = 0; i < 5; i++) beat(60 + i);
    chk("mid_fill_busy", 72'(busy), 72'd1);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_window", window, 72'd0);
    chk("arst_busy", 72'(busy), 72'd0);
    chk("arst_valid", 72'(window_valid), 72'd0);
    chk("arst_err", 72'(err), 72'd0);
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // fill abort during shift after 2 beats, with a stray shift_start
    fill_seq(1, 0); ack();
    shift_start = 1'b1; direction = 2'b01;
    @(negedge clk);
    shift_start = 1'b0; direction = 2'b00;
    beat(70);
    shift_start = 1'b1; direction = 2'b11;
    @(negedge clk);
    shift_start = 1'b0; direction = 2'b00;
    chk("shift_in_shift_err", 72'(err), 72'd1);
    beat(71);
    fill_seq(40, 0);
    chk("abort_win", window, mkwin(40, 41, 42, 43, 44, 45, 46, 47, 48));
    chk("abort_err", 72'(err), 72'd0);
    ack();

    // fill and shift together in IDLE: fill wins, no err
    shift_start = 1'b1; direction = 2'b01;
    fill_seq(50, 0);
    chk("coll_win", window, mkwin(50, 51, 52, 53, 54, 55, 56, 57, 58));
    chk("coll_err", 72'(err), 72'd0);
    ack();

`ifdef WINBUF_WIN_COUNT_EN
    chk("win_count", 72'(win_count), 72'(acks));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // fill_seq drops fill_start after one cycle; clear the paired shift too
  always @(negedge clk) if (fill_start == 1'b0 && shift_start && direction == 2'b01 && busy) begin
    shift_start = 1'b0;
    direction   = 2'b00;
  end

endmodule

// File: doc/window_buffer.md
# window_buffer

Assembles the 3x3 pixel neighbourhood for the Sobel datapath from the serial pixel stream returned by SRAM. Sits directly downstream of the read-address generator (move_control) and upstream of the gradient compute stage. Accepts a 9-pixel initial fill, then a 3-pixel update for each snake-scan move (right, left, down). Presents a complete window with a valid/ack handshake.

## Interface
- PIX_W, 8, pixel width in bits
- clk  in  1  clock, rising edge
- n_reset  in  1  asynchronous, active-low reset
- fill_start  in  1  pulse; begin 9-pixel initial fill
- shift_start  in  1  pulse; begin 3-pixel move update
- direction  in  2  01 right, 10 left, 11 down; 00 illegal; sampled on accepted shift_start
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  PIX_W  pixel from SRAM
- win_ack  in  1  consumer has taken the window
- window  out  9*PIX_W  flat window; element (r,c) at [PIX_W*(3r+c) +: PIX_W], r=0 top row, c=0 left column
- window_valid  out  1  window complete and stable
- busy  out  1  high in FILL or SHIFT
- err  out  1  sticky protocol error
- win_count  out  16  windows produced (only with WINBUF_WIN_COUNT_EN)

## Operation
- States: IDLE, FILL, SHIFT, READY. Counter cnt, 4 bits.
- IDLE: fill_start -> FILL, cnt=0, err cleared. Otherwise shift_start with a legal direction -> SHIFT, cnt=0, direction latched into dir_q. shift_start with direction 00 -> stay IDLE, err=1.
- fill_start and shift_start in the same cycle: the fill wins and the shift is dropped without error.
- FILL: each pix_valid writes pix_data to element cnt in row-major order (0..8), then cnt+1. The beat at cnt=8 -> READY.
- SHIFT, on the accepting cycle (the IDLE->SHIFT edge), the window is moved in place:
  - right: column 1 -> column 0, column 2 -> column 1.
  - left: column 1 -> column 2, column 0 -> column 1.
  - down: row 1 -> row 0, row 2 -> row 1.
  - The vacated column or row keeps its stale values until it is overwritten.
- SHIFT, three pix_valid beats then fill the vacated slots:
  - right: (0,2), (1,2), (2,2).
  - left: (0,0), (1,0), (2,0).
  - down: (2,0), (2,1), (2,2).
  - The beat at cnt=2 -> READY.
- READY: window_valid=1 and window held stable.
  - win_ack -> IDLE.
  - fill_start -> FILL. The window is discarded and no ack is needed.
  - shift_start in READY without win_ack: ignored, err=1.
- pix_valid in IDLE or READY: data dropped, err=1.
- fill_start during FILL or SHIFT: restarts FILL with cnt=0 and err cleared. This is a mid-operation abort.
- shift_start during FILL or SHIFT: ignored, err=1.
- err is sticky and clears only on an accepted fill_start.

## Timing
- Reset values:
  - state=IDLE, cnt=0, window all zeros.
  - window_valid=0, busy=0, err=0, win_count=0, dir_q=01.
- All outputs are registered. There is no combinational path from any input to any output.
- Fill latency: window_valid rises on the cycle after the 9th accepted pix_valid beat. Minimum is 10 cycles from fill_start with back-to-back pixels.
- Shift latency: window_valid rises on the cycle after the 3rd beat. Minimum is 4 cycles from shift_start.
- pix_valid may have gaps. Only asserted beats advance cnt.
- win_ack is sampled only in READY. window_valid falls on the cycle after win_ack.
- An asynchronous n_reset mid-fill or mid-shift returns all state to reset values immediately. Partial window contents are lost.

## Configuration
- WINBUF_WIN_COUNT_EN defined:
  - Adds a 16-bit win_count output port and register.
  - It increments on each READY->IDLE transition caused by win_ack.
  - It wraps from 0xFFFF to 0, and is cleared by reset only.
- Not defined: the port and register are absent. Behaviour is otherwise identical.

## Structure
- Shared package sobel_pkg holds:
  - dir_t enum: DIR_NONE=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11. These encodings are shared with move_control.
  - PIX_W default constant.
  - wb_state_t enum for IDLE, FILL, SHIFT and READY.
- Single module. The window register array and its shift/write logic stay inline, so no sub-module is needed.

## Test plan
- Fill: fill_start, then pixels 1..9 back-to-back -> window_valid at cycle 10; window row0={1,2,3}, row1={4,5,6}, row2={7,8,9}. Then win_ack -> valid=0 next cycle.
- Right shift: after the fill and ack, shift_start with dir=01, then pixels 10, 11, 12 -> window rows {2,3,10}, {5,6,11}, {8,9,12}; valid 4 cycles after shift_start.
- Left and down: from window rows {1,2,3}, {4,5,6}, {7,8,9}:
  - dir=10 with pixels 20, 21, 22 -> rows {20,1,2}, {21,4,5}, {22,7,8}.
  - dir=11 from the same base with pixels 30, 31, 32 -> rows {4,5,6}, {7,8,9}, {30,31,32}.
- Gapped input and protocol errors:
  - Pixels spaced 3 cycles apart -> the same contents as the fill test; valid one cycle after the 9th beat.
  - pix_valid while IDLE -> err=1; it stays set until the next fill_start.
  - shift_start with dir=00 -> err=1 and the state stays IDLE.
- Abort: n_reset asserted after 5 fill beats -> all outputs at reset values at once. Also, fill_start after 2 shift beats -> cnt restarts; 9 new pixels give a correct fresh window and err=0.
- Collision and count: fill_start together with shift_start in IDLE -> FILL taken and no err. With WINBUF_WIN_COUNT_EN, 3 acked windows -> win_count=3.
